// File: rtl/ir_fusion_filt.sv
// ir_fusion_filt
//   IR heading-fusion block. Boxcar-averages the left/right IR readings,
//   derives a wall-following heading correction (plus a derivative term) and
//   adds it to the desired heading. A FILL/TRACK/HOLD state machine keeps
//   fusion off after a wall-open change until the filter has refilled.
//
//   Build option: define IR_FUSE_SAT_EN to saturate the adjusted heading to
//   the signed W-bit range; otherwise it wraps (two's complement).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ir_vld          one-cycle strobe qualifying all sample inputs
//   lft_IR/rght_IR  unsigned IR readings
//   lft_opn/rght_opn wall-absent flags
//   IR_Dtrm         signed derivative term
//   en_fusion       enable IR correction of the heading
//   dsrd_hdng       signed desired heading
//   dsrd_hdng_adj   adjusted heading (registered, 2 cycles after ir_vld)
//   adj_vld         one-cycle strobe, dsrd_hdng_adj updated
//   fused           dsrd_hdng_adj carries IR correction
module ir_fusion_filt #(
  parameter int              W         = 12,
  parameter logic [W-1:0]    NOM_IR    = 12'h970,
  parameter int              LOG_DEPTH = 2,
  parameter int              HOLD_SMPL = 8,
  parameter int              ERR_SHFT  = 5,
  parameter int              DTRM_W    = 9,
  parameter int              DTRM_SHFT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ir_vld,
  input  logic [W-1:0]             lft_IR,
  input  logic [W-1:0]             rght_IR,
  input  logic                     lft_opn,
  input  logic                     rght_opn,
  input  logic signed [DTRM_W-1:0] IR_Dtrm,
  input  logic                     en_fusion,
  input  logic signed [W-1:0]      dsrd_hdng,
  output logic [W-1:0]             dsrd_hdng_adj,
  output logic                     adj_vld,
  output logic                     fused
);

  localparam int unsigned DEPTH = 1 << LOG_DEPTH;
  localparam int          SW    = W + LOG_DEPTH;
  localparam int          CW    = W + 2;
  localparam int          HW    = $clog2(HOLD_SMPL + 1);
  localparam int          FW    = LOG_DEPTH + 1;

  typedef enum logic [1:0] {S_FILL, S_TRACK, S_HOLD} state_t;

  state_t          r_state, w_nxt_state;

  logic [W-1:0]    r_lwin [DEPTH];
  logic [W-1:0]    r_rwin [DEPTH];
  logic [SW-1:0]   r_lsum, r_rsum;
  logic [FW-1:0]   r_fill_cnt;
  logic [HW-1:0]   r_hold_cnt;
  logic [1:0]      r_prev_opn;

  logic            r_s1_vld, r_s1_fuse;
  logic [1:0]      r_s1_opn;
  logic signed [DTRM_W-1:0] r_s1_dtrm;
  logic signed [W-1:0]      r_s1_dsrd;

  logic [1:0]      w_opn;
  logic            w_chg, w_fill_last, w_hold_last;
  logic            w_insert, w_clear, w_fuse_now;

  assign w_opn       = {lft_opn, rght_opn};
  assign w_chg       = ir_vld && (w_opn != r_prev_opn);
  assign w_fill_last = (r_fill_cnt == FW'(DEPTH - 1));
  assign w_hold_last = (r_hold_cnt == HW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FILL;
    else        r_state <= w_nxt_state;
  end

  // Next-state logic
  always_comb begin
    w_nxt_state = r_state;
    if (ir_vld) begin
      if (w_chg) begin
        w_nxt_state = S_HOLD;
      end else begin
        case (r_state)
          S_FILL:  if (w_fill_last) w_nxt_state = S_TRACK;
          S_HOLD:  if (w_hold_last) w_nxt_state = S_FILL;
          default: w_nxt_state = r_state;
        endcase
      end
    end
  end

  // Control outputs
  always_comb begin
    w_insert   = 1'b0;
    w_clear    = 1'b0;
    w_fuse_now = 1'b0;
    if (ir_vld) begin
      if (w_chg) begin
        w_clear = 1'b1;
      end else begin
        case (r_state)
          S_FILL: begin
            w_insert   = 1'b1;
            w_fuse_now = en_fusion && w_fill_last;
          end
          S_TRACK: begin
            w_insert   = 1'b1;
            w_fuse_now = en_fusion;
          end
          S_HOLD: begin
            // Hold expiry flushes the window so FILL starts from empty.
            w_clear = w_hold_last;
          end
          default: ;
        endcase
      end
    end
  end

  // Counters and previous wall-open flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_cnt <= '0;
      r_hold_cnt <= '0;
      r_prev_opn <= '0;
    end else if (ir_vld) begin
      r_prev_opn <= w_opn;
      if (w_clear)
        r_fill_cnt <= '0;
      else if (w_insert && r_state == S_FILL)
        r_fill_cnt <= r_fill_cnt + FW'(1);
      if (w_chg)
        r_hold_cnt <= HW'(HOLD_SMPL);
      else if (r_state == S_HOLD)
        r_hold_cnt <= r_hold_cnt - HW'(1);
    end
  end

  // Boxcar windows with running sums
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_lwin[i] <= '0;
        r_rwin[i] <= '0;
      end
      r_lsum <= '0;
      r_rsum <= '0;
    end else if (w_clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_lwin[i] <= '0;
        r_rwin[i] <= '0;
      end
      r_lsum <= '0;
      r_rsum <= '0;
    end else if (w_insert) begin
      r_lwin[0] <= lft_IR;
      r_rwin[0] <= rght_IR;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_lwin[i] <= r_lwin[i-1];
        r_rwin[i] <= r_rwin[i-1];
      end
      r_lsum <= r_lsum + SW'(lft_IR)  - SW'(r_lwin[DEPTH-1]);
      r_rsum <= r_rsum + SW'(rght_IR) - SW'(r_rwin[DEPTH-1]);
    end
  end

  // Stage 1: sample side-band that travels alongside the filter update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_fuse <= 1'b0;
      r_s1_opn  <= '0;
      r_s1_dtrm <= '0;
      r_s1_dsrd <= '0;
    end else begin
      r_s1_vld <= ir_vld;
      if (ir_vld) begin
        r_s1_fuse <= w_fuse_now;
        r_s1_opn  <= w_opn;
        r_s1_dtrm <= IR_Dtrm;
        r_s1_dsrd <= dsrd_hdng;
      end
    end
  end

  // Stage 2 datapath: error, correction, adjusted heading
  logic [W-1:0]         w_lavg, w_ravg;
  logic signed [W:0]    w_diff, w_err;
  logic signed [CW-1:0] w_err_x, w_dt_x, w_csum, w_corr, w_fin_x;
  logic [W-1:0]         w_fin;

  assign w_lavg = r_lsum[SW-1:LOG_DEPTH];
  assign w_ravg = r_rsum[SW-1:LOG_DEPTH];
  assign w_diff = $signed({1'b0, w_lavg}) - $signed({1'b0, w_ravg});

  always_comb begin
    w_err = '0;
    case (r_s1_opn)
      2'b10:   w_err = $signed({1'b0, NOM_IR}) - $signed({1'b0, w_ravg});
      2'b01:   w_err = $signed({1'b0, w_lavg}) - $signed({1'b0, NOM_IR});
      2'b00:   w_err = w_diff >>> 1;
      default: w_err = '0;
    endcase
  end

  assign w_err_x = {{(CW-W-1){w_err[W]}}, w_err};
  assign w_dt_x  = {{(CW-DTRM_W){r_s1_dtrm[DTRM_W-1]}}, r_s1_dtrm};
  assign w_csum  = (w_err_x >>> ERR_SHFT) + (w_dt_x <<< DTRM_SHFT);
  assign w_corr  = w_csum >>> 1;
  assign w_fin_x = {{(CW-W){r_s1_dsrd[W-1]}}, r_s1_dsrd} + w_corr;

`ifdef IR_FUSE_SAT_EN
  // In range when all bits above the W-bit sign agree with it.
  always_comb begin
    if (&w_fin_x[CW-1:W-1] || ~|w_fin_x[CW-1:W-1])
      w_fin = w_fin_x[W-1:0];
    else if (w_fin_x[CW-1])
      w_fin = {1'b1, {(W-1){1'b0}}};
    else
      w_fin = {1'b0, {(W-1){1'b1}}};
  end
`else
  logic w_unused_fin_hi;
  assign w_unused_fin_hi = &{1'b0, w_fin_x[CW-1:W]};
  assign w_fin = w_fin_x[W-1:0];
`endif

  // Stage 2 output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsrd_hdng_adj <= '0;
      adj_vld       <= 1'b0;
      fused         <= 1'b0;
    end else begin
      adj_vld <= r_s1_vld;
      if (r_s1_vld) begin
        dsrd_hdng_adj <= r_s1_fuse ? w_fin : r_s1_dsrd;
        fused         <= r_s1_fuse;
      end
    end
  end

endmodule
